// File: rtl/virq_inject.sv
// Virtual interrupt injector: queues hypervisor-raised IRQs and
// delivers them to the guest as Z80 mode-2 acknowledges.
module virq_inject #(
    parameter logic [7:0] BASE_PORT = 8'hC0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       m1_n,
    input  logic       iorq_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic [7:0] addr,
    input  logic [7:0] data_in,
    input  logic       trap_state,
    input  logic       virtual_enabled,
    input  logic       irq_sys_n,
    output logic       int_n,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       virq_active
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        ACK,
        DONE
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] pending;
    logic [7:0] pending_nxt;
    logic [7:0] enable;
    logic [7:0] base_vec;
    logic [2:0] win_idx;
    logic [2:0] top_idx;
    logic       owned;
    logic       owned_nxt;
    logic       prev_io;
    logic       retire;
    logic       hit;
    logic       wr_go;
    logic       rd_go;
    logic       ack_go;
    logic [7:0] req;
    logic [7:0] rd_val;
    logic       int_req;

    assign hit    = (addr[7:2] == BASE_PORT[7:2]);
    assign wr_go  = trap_state & hit & ~iorq_n & ~wr_n & m1_n & ~prev_io;
    assign rd_go  = trap_state & hit & ~iorq_n & ~rd_n & m1_n;
    assign ack_go = owned & ~m1_n & ~iorq_n;
    assign req    = pending & enable;

    // Fixed priority: the highest set request index wins.
    always_comb begin
        top_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (req[i]) top_idx = 3'(i);
        end
    end

    always_comb begin
        rd_val = 8'h00;
        case (addr[1:0])
            2'd0: rd_val = pending;
            2'd1: rd_val = req;
            2'd2: rd_val = enable;
            2'd3: rd_val = base_vec;
        endcase
    end

    always_comb begin
        data_out = 8'h00;
        if (ack_go) data_out = base_vec | {4'b0, win_idx, 1'b0};
        else if (rd_go) data_out = rd_val;
    end

    assign data_oe     = ack_go | rd_go;
    assign virq_active = (state == ACK);

    assign int_req = (|req) & ~trap_state & virtual_enabled
                   & irq_sys_n & (state == IDLE);

    always_comb begin
        state_nxt = state;
        owned_nxt = owned;
        retire    = 1'b0;
        case (state)
            IDLE: begin
                if (~m1_n & iorq_n & ~int_n) begin
                    state_nxt = ARM;
                    owned_nxt = 1'b1;
                end
            end
            ARM: begin
                if (~m1_n & ~iorq_n) begin
                    state_nxt = ACK;
                end else if (m1_n) begin
                    state_nxt = IDLE;
                    owned_nxt = 1'b0;
                end
            end
            ACK: begin
                if (iorq_n) begin
                    state_nxt = DONE;
                    retire    = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                owned_nxt = 1'b0;
            end
            default: begin
                state_nxt = IDLE;
                owned_nxt = 1'b0;
            end
        endcase
    end

    // Register writes land first; a retire on the same clk then clears its bit.
    always_comb begin
        pending_nxt = pending;
        if (wr_go && addr[1:0] == 2'd0) pending_nxt = pending | data_in;
        if (wr_go && addr[1:0] == 2'd1) pending_nxt = pending & ~data_in;
        if (retire) pending_nxt[win_idx] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            pending  <= 8'h00;
            enable   <= 8'h00;
            base_vec <= 8'h00;
            win_idx  <= 3'd0;
            owned    <= 1'b0;
            prev_io  <= 1'b0;
            int_n    <= 1'b1;
        end else begin
            state   <= state_nxt;
            owned   <= owned_nxt;
            pending <= pending_nxt;
            prev_io <= ~iorq_n;
            int_n   <= ~int_req;
            if (wr_go && addr[1:0] == 2'd2) enable <= data_in;
            if (wr_go && addr[1:0] == 2'd3) base_vec <= {data_in[7:1], 1'b0};
            if (m1_n && state == IDLE) win_idx <= top_idx;
        end
    end

endmodule

// File: tb/tb_virq_inject.sv
// Directed testbench for virq_inject: register table plus
// hand-written acknowledge sequences.
module tb_virq_inject;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       m1_n, iorq_n, rd_n, wr_n;
    logic [7:0] addr, data_in;
    logic       trap_state, virtual_enabled, irq_sys_n;
    logic       int_n;
    logic [7:0] data_out;
    logic       data_oe;
    logic       virq_active;

    int checks = 0;
    int errors = 0;

    virq_inject #(.BASE_PORT(8'hC0)) dut (
        .clk(clk), .reset_n(reset_n),
        .m1_n(m1_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
        .addr(addr), .data_in(data_in),
        .trap_state(trap_state), .virtual_enabled(virtual_enabled),
        .irq_sys_n(irq_sys_n),
        .int_n(int_n), .data_out(data_out), .data_oe(data_oe),
        .virq_active(virq_active)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       do_wr;
        logic [1:0] wport;
        logic [7:0] wdata;
        logic [1:0] rport;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic io_write(input logic [7:0] a, input logic [7:0] d);
        addr = a; data_in = d; iorq_n = 1'b0; wr_n = 1'b0;
        cyc(); cyc();
        iorq_n = 1'b1; wr_n = 1'b1;
        cyc();
    endtask

    task automatic io_read(input logic [7:0] a, output logic [7:0] d, output logic oe);
        addr = a; iorq_n = 1'b0; rd_n = 1'b0;
        #1;
        d = data_out; oe = data_oe;
        cyc();
        iorq_n = 1'b1; rd_n = 1'b1;
        cyc();
    endtask

    task automatic ack(output logic [7:0] v, output logic oe, output logic act);
        m1_n = 1'b0;
        cyc(); cyc();
        iorq_n = 1'b0;
        #1;
        v = data_out; oe = data_oe;
        cyc();
        act = virq_active;
        cyc();
        m1_n = 1'b1; iorq_n = 1'b1;
        cyc(); cyc();
    endtask

    logic [7:0] rv, v;
    logic       oe, act;

    initial begin
        tbl[0] = '{1'b1, 2'd2, 8'h0F, 2'd2, 8'h0F};
        tbl[1] = '{1'b1, 2'd0, 8'h33, 2'd0, 8'h33};
        tbl[2] = '{1'b0, 2'd0, 8'h00, 2'd1, 8'h03};
        tbl[3] = '{1'b1, 2'd1, 8'h01, 2'd0, 8'h32};
        tbl[4] = '{1'b1, 2'd0, 8'h80, 2'd1, 8'h02};
        tbl[5] = '{1'b1, 2'd3, 8'h47, 2'd3, 8'h46};
        tbl[6] = '{1'b1, 2'd3, 8'hFF, 2'd3, 8'hFE};
        tbl[7] = '{1'b1, 2'd1, 8'hFF, 2'd0, 8'h00};

        reset_n = 1'b0; m1_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        addr = 8'h00; data_in = 8'h00;
        trap_state = 1'b1; virtual_enabled = 1'b1; irq_sys_n = 1'b1;
        cyc(); cyc();
        chk("rst_int_n", {7'b0, int_n}, 8'h01);
        chk("rst_data_oe", {7'b0, data_oe}, 8'h00);
        chk("rst_data_out", data_out, 8'h00);
        chk("rst_virq_active", {7'b0, virq_active}, 8'h00);
        reset_n = 1'b1;
        cyc();

        for (int i = 0; i < 8; i++) begin
            if (tbl[i].do_wr) io_write(8'hC0 | {6'b0, tbl[i].wport}, tbl[i].wdata);
            io_read(8'hC0 | {6'b0, tbl[i].rport}, rv, oe);
            chk($sformatf("tbl%0d", i), rv, tbl[i].exp);
            chk($sformatf("tbl%0d_oe", i), {7'b0, oe}, 8'h01);
        end

        // Basic injection
        io_write(8'hC2, 8'h04);
        io_write(8'hC3, 8'h40);
        io_write(8'hC0, 8'h04);
        chk("basic_int_trap", {7'b0, int_n}, 8'h01);
        trap_state = 1'b0;
        cyc();
        chk("basic_int_low", {7'b0, int_n}, 8'h00);
        ack(v, oe, act);
        chk("basic_vec", v, 8'h44);
        chk("basic_oe", {7'b0, oe}, 8'h01);
        chk("basic_active", {7'b0, act}, 8'h01);
        cyc();
        chk("basic_int_after", {7'b0, int_n}, 8'h01);
        trap_state = 1'b1;
        io_read(8'hC0, rv, oe);
        chk("basic_pending", rv, 8'h00);

        // Priority
        io_write(8'hC2, 8'hFF);
        io_write(8'hC3, 8'h20);
        io_write(8'hC0, 8'h81);
        trap_state = 1'b0;
        cyc(); cyc();
        ack(v, oe, act);
        chk("prio_vec1", v, 8'h2E);
        trap_state = 1'b1;
        io_read(8'hC0, rv, oe);
        chk("prio_pending1", rv, 8'h01);
        trap_state = 1'b0;
        cyc(); cyc();
        chk("prio_int_again", {7'b0, int_n}, 8'h00);
        ack(v, oe, act);
        chk("prio_vec2", v, 8'h20);

        // Suppression by a real system interrupt
        trap_state = 1'b1;
        io_write(8'hC0, 8'h02);
        trap_state = 1'b0;
        cyc(); cyc();
        chk("sup_int_low", {7'b0, int_n}, 8'h00);
        irq_sys_n = 1'b0;
        cyc();
        chk("sup_int_high", {7'b0, int_n}, 8'h01);
        ack(v, oe, act);
        chk("sup_oe", {7'b0, oe}, 8'h00);
        chk("sup_active", {7'b0, act}, 8'h00);
        irq_sys_n = 1'b1;
        trap_state = 1'b1;
        io_read(8'hC0, rv, oe);
        chk("sup_pending", rv, 8'h02);

        // Opcode fetch while armed
        trap_state = 1'b0;
        cyc(); cyc();
        chk("m1_int_low", {7'b0, int_n}, 8'h00);
        m1_n = 1'b0;
        cyc();
        m1_n = 1'b1;
        cyc();
        chk("m1_int_arm", {7'b0, int_n}, 8'h01);
        cyc();
        chk("m1_int_reassert", {7'b0, int_n}, 8'h00);

        // Guest access blocked
        io_write(8'hC0, 8'hFF);
        io_read(8'hC0, rv, oe);
        chk("guest_oe", {7'b0, oe}, 8'h00);
        trap_state = 1'b1;
        io_read(8'hC0, rv, oe);
        chk("guest_pending", rv, 8'h02);

        // Reset during an acknowledge
        trap_state = 1'b0;
        cyc(); cyc();
        m1_n = 1'b0;
        cyc(); cyc();
        iorq_n = 1'b0;
        cyc();
        chk("rst_mid_active", {7'b0, virq_active}, 8'h01);
        chk("rst_mid_oe_on", {7'b0, data_oe}, 8'h01);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_oe", {7'b0, data_oe}, 8'h00);
        chk("rst_mid_int", {7'b0, int_n}, 8'h01);
        chk("rst_mid_act", {7'b0, virq_active}, 8'h00);
        m1_n = 1'b1; iorq_n = 1'b1;
        cyc();
        reset_n = 1'b1;
        trap_state = 1'b1;
        cyc();
        for (int p = 0; p < 4; p++) begin
            io_read(8'hC0 | 8'(p), rv, oe);
            chk($sformatf("rst_reg%0d", p), rv, 8'h00);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/virq_inject.md
# virq_inject

Virtual interrupt injector for the Nabu MegaMapper CPLD. The trap logic intercepts real system interrupts and enters trap mode. This block runs the other direction: trap-mode (hypervisor) software queues virtual interrupts, and the block delivers them to the guest. It drives the guest's INT line, answers the Z80 mode-2 interrupt acknowledge with a prioritised vector, and retires the serviced request.

## Interface
Parameters:
- BASE_PORT, 8'hC0: I/O base of the 4-port register window; decode is addr[7:2] == BASE_PORT[7:2].

Ports:
- clk  in  1  Z80 CPU clock; all Z80 strobes are sampled on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- m1_n, iorq_n, rd_n, wr_n  in  1 each  Z80 bus strobes.
- addr  in  8  Z80 A[7:0].
- data_in  in  8  Z80 data bus input.
- trap_state  in  1  trap mode active (hypervisor running).
- virtual_enabled  in  1  virtualisation enabled.
- irq_sys_n  in  1  raw system interrupt request.
- int_n  out  1  virtual INT to the CPU (open-drain-style; the top level ANDs it with the system INT).
- data_out  out  8  value driven onto the data bus.
- data_oe  out  1  data bus drive enable.
- virq_active  out  1  a virtual acknowledge is in progress.

## Operation
Registers, all reset to 0:
- pending[7:0]
- enable[7:0]
- base_vec[7:0]
- win_idx[2:0]
- owned
- state
- prev_io

I/O window (accesses honoured only when trap_state=1; ignored otherwise):
- +0 W: pending |= data_in. +0 R: pending.
- +1 W: pending &= ~data_in. +1 R: pending & enable.
- +2 W/R: enable.
- +3 W/R: base_vec. Bit 0 is forced to 0 on write; IM2 vectors are even.

Access rules:
- An I/O write commits once per access, on the first clk where iorq_n=0, wr_n=0, m1_n=1, and prev_io=0.
- prev_io is the registered value of !iorq_n.
- Reads drive data_oe=1 combinationally while iorq_n=0, rd_n=0, m1_n=1, trap_state=1, and the window decodes.

Request and priority:
- req = pending & enable.
- Priority is fixed: the highest set bit index wins.
- win_idx updates every clk while m1_n=1 and state=IDLE, and freezes otherwise.
- int_n (registered) = 0 iff req≠0, trap_state=0, virtual_enabled=1, irq_sys_n=1, and state=IDLE.

State machine:
- IDLE → ARM: on a clk with m1_n=0, iorq_n=1, and int_n=0. Sets owned=1.
- ARM → ACK: on a clk with m1_n=0 and iorq_n=0 (the acknowledge).
- ARM → IDLE: on a clk with m1_n=1. This was an opcode fetch, not an acknowledge. Clears owned.
- ACK → DONE: on a clk with iorq_n=1. Clears pending[win_idx].
- DONE → IDLE: unconditional; clears owned.

Acknowledge drive:
- data_out during ack = base_vec | {4'b0, win_idx, 1'b0}.
- data_oe = owned & !m1_n & !iorq_n, combinational, OR the register-read term.
- virq_active = (state==ACK).

Boundary cases:
- An ack with owned=0 (a real system interrupt) gives data_oe=0 and no state change.
- If trap_state rises mid-ack, the ack still completes and clears its bit.
- If the hypervisor disables a bit after ARM, the ack still uses the frozen win_idx.
- A clear write to a bit and an ack retiring the same bit cannot overlap; both are M1 and I/O cycles. If a write and a retire land on the same clk, the write is applied first and then the retire bit is cleared.
- reset_n low mid-ack: all registers are 0 immediately, data_oe=0, int_n=1.

## Timing
- Reset values: int_n=1, data_oe=0, data_out=0, virq_active=0.
- int_n asserts or deasserts 1 clk after the qualifying condition changes.
- int_n drops to 1 within 1 clk of trap_state rising or irq_sys_n falling.
- Vector latency: data_oe rises in the same clk phase that iorq_n falls in an owned ack (combinational), and is stable before the Z80 samples it at T3.
- Retire: the pending bit clears 1 clk after iorq_n returns high. int_n may re-assert 2 clk later if req≠0.
- Register write to effect: 1 clk.

## Test plan
- **Basic injection.** Trap mode: write enable=8'h04, base_vec=8'h40, pending=8'h04, then trap_state→0. Expect int_n=0 after 1 clk. Run an IM2 ack: data_out=8'h44, data_oe=1 during ack. After ack, pending=0 and int_n=1.
- **Priority.** Set pending=8'h81, enable=8'hFF, base_vec=8'h20. First ack gives 8'h2E and pending=8'h01. Second ack gives 8'h20.
- **Suppression.** With req≠0, drive irq_sys_n=0 → int_n=1 in 1 clk. A system ack with owned=0 gives data_oe=0 and leaves pending unchanged.
- **Non-ack M1.** int_n=0 and the next M1 is an opcode fetch with iorq_n staying high: ARM→IDLE, pending unchanged, int_n re-asserts.
- **Guest access blocked.** trap_state=0, guest writes 8'hFF to BASE_PORT+0: pending unchanged, data_oe=0 on a guest read.
- **Reset mid-ack.** Pulse reset_n low during ack: data_oe=0 and int_n=1 immediately, all registers read 0 afterwards.
